fpu_ss_issue_buffer: RTL

- Sits directly upstream of the FPU subsystem predecoder, between the core's offload issue interface and the FPU decoder/compute pipeline.
- Drives the instruction word into the predecoder and returns the predecoder's response to the core as the issue response.
- Captures each accepted instruction, its ID and the register operands it needs into a small in-order FIFO, which the downstream FPU decode stage drains.
- Rejected instructions are answered but never buffered.

---
 rtl/fpu_ss_issue_buffer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/fpu_ss_issue_buffer.sv
// -----------------------------------------------------------------------------
// fpu_ss_issue_buffer
//
// Purpose:
//   Front end of the FPU subsystem. It forwards each offered instruction word
//   to the predecoder and returns the predecoder's verdict to the core as the
//   issue response. Accepted instructions are captured, together with their
//   ID and the integer operands they use, into a small in-order FIFO. The FPU
//   decode stage drains that FIFO. Rejected instructions are answered in the
//   same cycle and are never buffered.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   flush_i                      synchronous flush of all buffered entries
//   x_issue_*                    core offload issue request/response
//   x_rs_i / x_rs_valid_i        integer operand values and their valids
//   prd_*                        predecoder request/response
//   instr_*                      FIFO head towards the decode stage
//   empty_o / full_o             FIFO occupancy flags
//
// Optional feature (macro FPU_SS_ISSUE_STATS_EN):
//   Adds the stat_accepted_o and stat_rejected_o outputs. These are
//   saturating 32-bit counters of pushes and of reject handshakes.
// -----------------------------------------------------------------------------
module fpu_ss_issue_buffer #(
    parameter int unsigned Depth   = 4,
    parameter int unsigned IdWidth = 4,
    parameter int unsigned NumRs   = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  x_issue_valid_i,
    output logic                  x_issue_ready_o,
    input  logic [31:0]           x_issue_instr_i,
    input  logic [IdWidth-1:0]    x_issue_id_i,
    input  logic [NumRs*32-1:0]   x_rs_i,
    input  logic [NumRs-1:0]      x_rs_valid_i,
    output logic                  x_issue_resp_accept_o,
    output logic                  x_issue_resp_writeback_o,
    output logic                  x_issue_resp_is_mem_op_o,
    output logic [31:0]           prd_instr_o,
    input  logic                  prd_accept_i,
    input  logic                  prd_writeback_i,
    input  logic                  prd_is_mem_op_i,
    input  logic [NumRs-1:0]      prd_use_rs_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [31:0]           instr_data_o,
    output logic [IdWidth-1:0]    instr_id_o,
    output logic [NumRs*32-1:0]   instr_rs_o,
    output logic                  empty_o,
    output logic                  full_o
`ifdef FPU_SS_ISSUE_STATS_EN
    ,
    output logic [31:0]           stat_accepted_o,
    output logic [31:0]           stat_rejected_o
`endif
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW-1:0] PtrOne   = PtrW'(1);
    localparam logic [PtrW:0]   CntOne   = (PtrW + 1)'(1);
    localparam logic [PtrW:0]   CntDepth = (PtrW + 1)'(Depth);

    // -------------------------------------------------------------------------
    // Predecode path and operand readiness
    // -------------------------------------------------------------------------
    logic [NumRs-1:0]    rs_ok_vec;
    logic [NumRs*32-1:0] rs_masked;
    logic                rs_ok;

    // Each operand is either unused or already valid. Unused operands are
    // stored as zero so that stale register values never reach the pipeline.
    for (genvar gi = 0; gi < NumRs; gi++) begin : g_rs
        assign rs_ok_vec[gi]          = !prd_use_rs_i[gi] || x_rs_valid_i[gi];
        assign rs_masked[gi*32 +: 32] = prd_use_rs_i[gi] ? x_rs_i[gi*32 +: 32] : 32'h0;
    end

    assign rs_ok = &rs_ok_vec;

    assign prd_instr_o              = x_issue_instr_i;
    assign x_issue_resp_accept_o    = x_issue_valid_i & prd_accept_i;
    assign x_issue_resp_writeback_o = x_issue_valid_i & prd_writeback_i;
    assign x_issue_resp_is_mem_op_o = x_issue_valid_i & prd_is_mem_op_i;

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]   count_q,  count_d;
    logic            reject_hs;
    logic            accept_ok;
    logic            push;
    logic            pop;

    assign full_o        = (count_q == CntDepth);
    assign empty_o       = (count_q == '0);
    assign instr_valid_o = !empty_o;

    // A reject completes at once. An accept also needs its operands and a
    // free slot. Fullness comes from the registered count only, so a pop in
    // the same cycle does not make room for a push.
    assign reject_hs       = x_issue_valid_i & !prd_accept_i & !flush_i;
    assign accept_ok       = x_issue_valid_i & prd_accept_i & rs_ok & !full_o;
    assign x_issue_ready_o = !flush_i & (reject_hs | accept_ok);

    assign push = x_issue_valid_i & x_issue_ready_o & prd_accept_i;
    assign pop  = instr_valid_o & instr_ready_i;

    // -------------------------------------------------------------------------
    // Pointer / count next-state
    // -------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            // The flush wins over push and pop. A pop in this cycle is dropped.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrOne;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CntOne;
                2'b01:   count_d = count_q - CntOne;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // -------------------------------------------------------------------------
    // Entry storage
    // -------------------------------------------------------------------------
    // The storage itself is not reset. Only occupancy is reset. The head
    // outputs are forced to zero while the FIFO is empty, so stale contents
    // are never visible after a reset or a flush.
    logic [31:0]         instr_mem_q [Depth];
    logic [IdWidth-1:0]  id_mem_q    [Depth];
    logic [NumRs*32-1:0] rs_mem_q    [Depth];

    always_ff @(posedge clk_i) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= x_issue_instr_i;
            id_mem_q[wr_ptr_q]    <= x_issue_id_i;
            rs_mem_q[wr_ptr_q]    <= rs_masked;
        end
    end

    assign instr_data_o = empty_o ? 32'h0 : instr_mem_q[rd_ptr_q];
    assign instr_id_o   = empty_o ? '0    : id_mem_q[rd_ptr_q];
    assign instr_rs_o   = empty_o ? '0    : rs_mem_q[rd_ptr_q];

`ifdef FPU_SS_ISSUE_STATS_EN
    // -------------------------------------------------------------------------
    // Saturating statistics counters. A flush does not clear them.
    // -------------------------------------------------------------------------
    logic [31:0] stat_accepted_q, stat_accepted_d;
    logic [31:0] stat_rejected_q, stat_rejected_d;

    always_comb begin
        stat_accepted_d = stat_accepted_q;
        stat_rejected_d = stat_rejected_q;
        if (push && (stat_accepted_q != 32'hFFFF_FFFF)) begin
            stat_accepted_d = stat_accepted_q + 32'd1;
        end
        if (reject_hs && (stat_rejected_q != 32'hFFFF_FFFF)) begin
            stat_rejected_d = stat_rejected_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_accepted_q <= '0;
            stat_rejected_q <= '0;
        end else begin
            stat_accepted_q <= stat_accepted_d;
            stat_rejected_q <= stat_rejected_d;
        end
    end

    assign stat_accepted_o = stat_accepted_q;
    assign stat_rejected_o = stat_rejected_q;
`endif

endmodule
